// File: rtl/alu_sequencer.sv
// alu_sequencer: two-port round-robin command sequencer that drives a multi-cycle ALU.
// Define ALU_SEQ_REPEAT_EN to honour the per-command repeat field (repeat+1 passes).
`ifndef OP_BITS
`define OP_BITS 4
`endif

module alu_sequencer #(
  parameter int LOG2_NR  = 3,
  parameter int OP_BITS  = `OP_BITS,
  parameter int CNT_BITS = 4,
  localparam int CMD_BITS = OP_BITS + 2*LOG2_NR + 1 + CNT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [CMD_BITS-1:0] req_cmd0,
  input  logic [CMD_BITS-1:0] req_cmd1,
  output logic                alu_op_valid,
  output logic [OP_BITS-1:0]  alu_operation,
  output logic [LOG2_NR-1:0]  alu_reg1,
  output logic [LOG2_NR-1:0]  alu_reg2,
  output logic                alu_pair_op,
  input  logic                alu_op_done,
  input  logic [3:0]          alu_flags,
  output logic                rsp_valid,
  output logic                rsp_port,
  output logic [3:0]          rsp_flags
);

  localparam int FIELD_BITS = CMD_BITS - CNT_BITS;
  localparam int PAIR_POS   = 0;
  localparam int REG2_LSB   = 1;
  localparam int REG1_LSB   = REG2_LSB + LOG2_NR;
  localparam int OP_LSB     = REG1_LSB + LOG2_NR;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t                state, state_nxt;
  logic                  last_grant;
  logic [1:0]            grant;
  logic                  grant_port;
  logic                  accept;
  logic [CMD_BITS-1:0]   cmd_sel;
  logic [FIELD_BITS-1:0] hold_fields;
  logic                  hold_port;
  logic                  last_pass;
  logic                  rsp_port_q;
  logic [3:0]            rsp_flags_q;

  // Round-robin grant, only offered while idle; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign grant_port = grant[1];
  assign accept     = |grant;
  assign req_ready  = grant;
  assign cmd_sel    = grant_port ? req_cmd1 : req_cmd0;

`ifdef ALU_SEQ_REPEAT_EN
  logic [CNT_BITS-1:0] pass_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt <= '0;
    end else if (accept) begin
      pass_cnt <= cmd_sel[CNT_BITS-1:0];
    end else if (state == RUN && alu_op_done && pass_cnt != '0) begin
      pass_cnt <= pass_cnt - 1'b1;
    end
  end

  assign last_pass = (pass_cnt == '0);
`else
  logic unused_repeat_bits;

  assign unused_repeat_bits = ^cmd_sel[CNT_BITS-1:0];
  assign last_pass          = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    alu_op_valid = 1'b0;
    rsp_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        alu_op_valid = 1'b1;
        if (alu_op_done && last_pass) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= 1'b1;
      hold_fields <= '0;
      hold_port   <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_flags_q <= 4'b0000;
    end else begin
      if (accept) begin
        last_grant  <= grant_port;
        hold_fields <= cmd_sel[CMD_BITS-1:CNT_BITS];
        hold_port   <= grant_port;
      end
      if (state == RESP) begin
        rsp_port_q  <= hold_port;
        rsp_flags_q <= alu_flags;
      end
    end
  end

  assign alu_operation = hold_fields[OP_LSB +: OP_BITS];
  assign alu_reg1      = hold_fields[REG1_LSB +: LOG2_NR];
  assign alu_reg2      = hold_fields[REG2_LSB +: LOG2_NR];
  assign alu_pair_op   = hold_fields[PAIR_POS];

  // Response fields pass the live ALU flags through on the pulse, then hold.
  assign rsp_port  = rsp_valid ? hold_port : rsp_port_q;
  assign rsp_flags = rsp_valid ? alu_flags : rsp_flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table vectors, directed corner sequences and random traffic
// checked against a transaction-level model of the sequencer.
`ifndef OP_BITS
`define OP_BITS 4
`endif

module tb_alu_sequencer;
  localparam int OPB  = `OP_BITS;
  localparam int LNR  = 3;
  localparam int CNB  = 4;
  localparam int CMDB = OPB + 2*LNR + 1 + CNB;
`ifdef ALU_SEQ_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [CMDB-1:0] req_cmd0, req_cmd1;
  logic            alu_op_valid;
  logic [OPB-1:0]  alu_operation;
  logic [LNR-1:0]  alu_reg1, alu_reg2;
  logic            alu_pair_op;
  logic            alu_op_done;
  logic [3:0]      alu_flags;
  logic            rsp_valid;
  logic            rsp_port;
  logic [3:0]      rsp_flags;

  alu_sequencer #(.LOG2_NR(LNR), .OP_BITS(OPB), .CNT_BITS(CNB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .alu_op_valid(alu_op_valid),
    .alu_operation(alu_operation), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
    .alu_pair_op(alu_pair_op), .alu_op_done(alu_op_done), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_flags(rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: every pass lasts alu_len cycles, done on the last one.
  int alu_len = 1;
  int alu_cyc = 0;
  always @(posedge clk) begin
    if (!alu_op_valid || alu_op_done) alu_cyc <= 0;
    else alu_cyc <= alu_cyc + 1;
  end
  assign alu_op_done = alu_op_valid && (alu_cyc == alu_len - 1);

  int total = 0;
  int bad   = 0;

  // Transaction-level model: one outstanding command, counted ALU-busy cycles.
  bit             busy = 1'b0;
  bit             m_last = 1'b1;
  bit             m_port = 1'b0;
  logic [OPB-1:0] m_op;
  logic [LNR-1:0] m_r1, m_r2;
  logic           m_pair;
  int             m_total = 0;
  int             m_act = 0;
  logic           m_rsp_port = 1'b0;
  logic [3:0]     m_rsp_flags = 4'b0000;

  logic [1:0] s_acc;
  logic       s_aov, s_rsp, s_port;
  logic [3:0] s_flags;

  typedef struct {
    int             port;
    logic [OPB-1:0] op;
    logic [LNR-1:0] r1;
    logic [LNR-1:0] r2;
    logic           pair;
    logic [CNB-1:0] rep;
    int             len;
    logic [3:0]     flags;
    int             exp_aov;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [1:0]      er;
    logic            ea, es, ep;
    logic [3:0]      ef;
    logic [CMDB-1:0] c;
    er = 2'b00;
    if (!busy) er = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
    ea = busy && (m_act < m_total);
    es = busy && (m_act == m_total);
    ep = es ? m_port : m_rsp_port;
    ef = es ? alu_flags : m_rsp_flags;
    s_aov = alu_op_valid; s_rsp = rsp_valid; s_port = rsp_port; s_flags = rsp_flags;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("alu_op_valid", 32'(alu_op_valid), 32'(ea));
    chk("rsp_valid", 32'(rsp_valid), 32'(es));
    chk("rsp_port", 32'(rsp_port), 32'(ep));
    chk("rsp_flags", 32'(rsp_flags), 32'(ef));
    if (ea) begin
      chk("alu_operation", 32'(alu_operation), 32'(m_op));
      chk("alu_reg1", 32'(alu_reg1), 32'(m_r1));
      chk("alu_reg2", 32'(alu_reg2), 32'(m_r2));
      chk("alu_pair_op", 32'(alu_pair_op), 32'(m_pair));
      m_act++;
    end
    if (es) begin
      m_rsp_port = m_port; m_rsp_flags = alu_flags; busy = 1'b0;
    end
    s_acc = req_valid & er & {2{~reset}};
    if (s_acc != 2'b00) begin
      c = s_acc[1] ? req_cmd1 : req_cmd0;
      busy = 1'b1; m_port = s_acc[1]; m_last = s_acc[1]; m_act = 0;
      {m_op, m_r1, m_r2, m_pair} = c[CMDB-1:CNB];
      m_total = (REP_ON ? int'(c[CNB-1:0]) + 1 : 1) * alu_len;
    end
    if (reset) begin
      busy = 1'b0; m_last = 1'b1; m_rsp_port = 1'b0; m_rsp_flags = 4'b0000;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (s_acc[0]) req_valid[0] = 1'b0;
    if (s_acc[1]) req_valid[1] = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int              aov_n = 0;
    bit              seen = 1'b0;
    logic            port_seen = 1'b0;
    logic [3:0]      fl = 4'b0000;
    logic [CMDB-1:0] c;
    alu_len = v.len; alu_flags = v.flags;
    c = {v.op, v.r1, v.r2, v.pair, v.rep};
    if (v.port == 0) begin req_cmd0 = c; req_valid[0] = 1'b1; end
    else begin req_cmd1 = c; req_valid[1] = 1'b1; end
    for (int k = 0; k < 400 && !seen; k++) begin
      tick();
      if (s_aov) aov_n++;
      if (s_rsp) begin seen = 1'b1; port_seen = s_port; fl = s_flags; end
    end
    chk($sformatf("vec%0d_done", idx), 32'(seen), 32'd1);
    chk($sformatf("vec%0d_aov_cycles", idx), 32'(aov_n), 32'(v.exp_aov));
    chk($sformatf("vec%0d_port", idx), 32'(port_seen), 32'(v.port));
    chk($sformatf("vec%0d_flags", idx), 32'(fl), 32'(v.flags));
  endtask

  initial begin
    int              n;
    int              rsp_n;
    int              ports[4];
    logic [CMDB-1:0] c;

    vecs[0] = '{0, OPB'(1),  3'd2, 3'd3, 1'b0, 4'd0,  4, 4'b0000, 4};
    vecs[1] = '{1, OPB'(5),  3'd7, 3'd0, 1'b1, 4'd0,  1, 4'b1001, 1};
    vecs[2] = '{0, OPB'(2),  3'd1, 3'd6, 1'b0, 4'd2,  8, 4'b1001, REP_ON ? 24 : 8};
    vecs[3] = '{1, OPB'(15), 3'd0, 3'd7, 1'b1, 4'd1,  3, 4'b0110, REP_ON ? 6 : 3};
    vecs[4] = '{0, OPB'(9),  3'd5, 3'd4, 1'b1, 4'd15, 2, 4'b1111, REP_ON ? 32 : 2};
    vecs[5] = '{1, OPB'(3),  3'd3, 3'd3, 1'b0, 4'd0,  5, 4'b0000, 5};

    reset = 1'b1; req_valid = 2'b00; req_cmd0 = '0; req_cmd1 = '0; alu_flags = 4'b0000;
    @(posedge clk);
    #1;
    tick();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Both ports requesting continuously from a fresh reset: strict alternation.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    alu_len = 2;
    req_cmd0 = {OPB'(4), 3'd1, 3'd2, 1'b0, 4'd0};
    req_cmd1 = {OPB'(6), 3'd3, 3'd4, 1'b1, 4'd0};
    req_valid = 2'b11;
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      tick();
      if (s_rsp) begin ports[n] = int'(s_port); n++; end
      if (n < 4) req_valid = 2'b11;
    end
    req_valid = 2'b00;
    chk("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(ports[i]), 32'(i % 2));

    // Abort mid-RUN: last grant was port 0, yet reset must hand the next tie to port 0.
    alu_len = 10;
    req_cmd0 = {OPB'(7), 3'd6, 3'd5, 1'b0, 4'd0};
    req_valid = 2'b01;
    tick();
    chk("abort_accept", 32'(s_acc), 32'h1);
    rsp_n = 0;
    tick(); rsp_n += int'(s_rsp);
    tick(); rsp_n += int'(s_rsp);
    reset = 1'b1;
    tick(); rsp_n += int'(s_rsp);
    reset = 1'b0;
    tick(); rsp_n += int'(s_rsp);
    chk("abort_aov_off", 32'(s_aov), 32'd0);
    chk("abort_no_rsp", 32'(rsp_n), 32'd0);
    req_valid = 2'b11;
    n = 0;
    for (int k = 0; k < 5 && n == 0; k++) begin
      tick();
      if (s_acc != 2'b00) n = int'(s_acc);
    end
    chk("abort_next_grant", 32'(n), 32'h1);
    req_valid = 2'b00;
    for (int k = 0; k < 100 && busy; k++) tick();
    chk("abort_drain", 32'(busy), 32'd0);

    // Random traffic with random ALU latency, flags and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] && $urandom_range(0, 1) == 1) begin
          c = {OPB'($urandom), LNR'($urandom), LNR'($urandom), 1'($urandom),
               CNB'($urandom_range(0, 3))};
          if (p == 0) req_cmd0 = c; else req_cmd1 = c;
          req_valid[p] = 1'b1;
        end
      end
      if (!busy) alu_len = $urandom_range(1, 4);
      alu_flags = 4'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    reset = 1'b0;
    req_valid = 2'b00;
    for (int k = 0; k < 300 && busy; k++) tick();
    chk("random_drain", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter LOG2_NR, default 3, register index width.
REQ-002 SHALL have parameter OP_BITS, default `OP_BITS, ALU operation code width.
REQ-003 SHALL have parameter CNT_BITS, default 4, repeat count width.
REQ-004 SHALL define CMD_BITS = OP_BITS+2*LOG2_NR+1+CNT_BITS; command word packed MSB..LSB: op, reg1, reg2, pair, repeat.
REQ-005 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_valid  input  2  per-port command valid (port 0 = decoder, port 1 = debug).
REQ-008 req_ready  output  2  per-port command accepted this cycle when valid&ready.
REQ-009 req_cmd0, req_cmd1  input  CMD_BITS each  command words for ports 0 and 1.
REQ-010 alu_op_valid  output  1  ALU op request.
REQ-011 alu_operation  output  OP_BITS  op field of held command.
REQ-012 alu_reg1, alu_reg2  output  LOG2_NR each  register fields of held command.
REQ-013 alu_pair_op  output  1  pair field of held command.
REQ-014 alu_op_done  input  1  ALU last-cycle indication.
REQ-015 alu_flags  input  4  {c,v,s,z} from ALU.
REQ-016 rsp_valid  output  1  one-cycle completion pulse.
REQ-017 rsp_port  output  1  port that issued the completed command.
REQ-018 rsp_flags  output  4  alu_flags sampled on the rsp_valid cycle.

Function
REQ-019 SHALL implement states IDLE, RUN, RESP.
REQ-020 req_ready SHALL be nonzero only in IDLE, with at most one bit set.
REQ-021 In IDLE, one valid port SHALL be granted; both valid SHALL grant the port not granted last (round-robin); last_grant resets to 1 so port 0 wins first.
REQ-022 On valid&ready, the command SHALL be latched into a holding register and the FSM SHALL enter RUN next cycle; last_grant updates to the granted port.
REQ-023 In RUN, alu_op_valid SHALL be 1 and all alu_* fields SHALL be driven from the holding register, stable until completion.
REQ-024 A command SHALL execute repeat+1 ALU passes; pass counter loaded with repeat at acceptance.
REQ-025 On alu_op_done with counter nonzero, counter SHALL decrement and alu_op_valid SHALL stay 1 with unchanged fields (back-to-back pass, no bubble).
REQ-026 On alu_op_done with counter zero, the FSM SHALL enter RESP; alu_op_valid SHALL be 0 in RESP.
REQ-027 In RESP, rsp_valid SHALL be 1 for exactly one cycle with rsp_port = granted port and rsp_flags = alu_flags; next state IDLE.
REQ-028 Outside RESP, rsp_valid SHALL be 0; rsp_port/rsp_flags hold last values.
REQ-029 Minimum command latency SHALL be acceptance + passes*ALU cycles + 1 RESP cycle + 1 IDLE cycle before next acceptance.
REQ-030 Requests arriving during RUN/RESP SHALL be held off (ready=0), not dropped; requesters keep valid asserted.

Reset
REQ-031 reset SHALL force IDLE, clear counter and holding register, set last_grant=1.
REQ-032 After reset, alu_op_valid=0, rsp_valid=0, req_ready reflects IDLE arbitration, rsp_port=0, rsp_flags=0.
REQ-033 Reset mid-RUN SHALL abort the command with no rsp_valid pulse; alu_op_valid=0 from the next cycle.

Configuration
REQ-034 Macro ALU_SEQ_REPEAT_EN defined: repeat field honoured per REQ-024/025.
REQ-035 ALU_SEQ_REPEAT_EN undefined: repeat field ignored, counter not implemented, every command exactly one pass; command word layout unchanged.

Verification
REQ-036 Port 0 cmd op=ADD, reg1=2, reg2=3, pair=0, repeat=0; ALU model done after 4 cycles -> alu_op_valid high 4 cycles, then rsp_valid=1 once, rsp_port=0.
REQ-037 Both ports valid from reset, repeat=0 -> grant order 0,1,0,1; each rsp_port matches.
REQ-038 With ALU_SEQ_REPEAT_EN, repeat=2, 8-cycle passes -> alu_op_valid continuous 24 cycles, fields stable, single rsp_valid; without macro -> 8 cycles.
REQ-039 alu_flags=4'b1001 during RESP -> rsp_flags=4'b1001.
REQ-040 Reset asserted 2 cycles into RUN -> no rsp_valid, alu_op_valid=0 next cycle, next grant goes to port 0.
